// File: rtl/tinyalu_pkg.sv
// Shared opcode and state encodings for tinyalu.
// The single-cycle datapath function is also used by the top.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'd0,
    add_op = 3'd1,
    and_op = 3'd2,
    xor_op = 3'd3,
    mul_op = 3'd4,
    rst_op = 3'd7
  } operation_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_WAIT_REL
  } state_t;

  // Non-multiply ops; no_op and reserved opcodes keep the previous result.
  function automatic logic [15:0] alu_single(input logic [2:0]  op,
                                             input logic [7:0]  a,
                                             input logic [7:0]  b,
                                             input logic [15:0] prev);
    logic [15:0] r;
    case (op)
      add_op:  r = {7'b0, ({1'b0, a} + {1'b0, b})};
      and_op:  r = {8'b0, (a & b)};
      xor_op:  r = {8'b0, (a ^ b)};
      rst_op:  r = '0;
      default: r = prev;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tinyalu_mul_pipe.sv
// Fixed-latency registered 8x8 multiplier with a matching valid chain.
// Reset flushes both the data and the valid stages.
module tinyalu_mul_pipe #(
  parameter int unsigned STAGES = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  input  logic        valid_i,
  output logic [15:0] prod_o,
  output logic        valid_o
);

  logic [15:0] prod_q [STAGES];
  logic        vld_q  [STAGES];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        prod_q[i] <= '0;
        vld_q[i]  <= 1'b0;
      end
    end else begin
      prod_q[0] <= 16'(a_i) * 16'(b_i);
      vld_q[0]  <= valid_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        prod_q[i] <= prod_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  assign prod_o  = prod_q[STAGES-1];
  assign valid_o = vld_q[STAGES-1];

endmodule

// File: rtl/tinyalu.sv
// 8-bit ALU with start/done handshake; add/and/xor complete in one clock,
// multiply runs through a MUL_LATENCY-stage pipeline.
module tinyalu
  import tinyalu_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result
);

  localparam int unsigned CW       = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;
  localparam int unsigned CNT_LAST = (MUL_LATENCY >= 2) ? (MUL_LATENCY - 2) : 0;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    a_q, a_d, b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic          done_q, done_d;
  logic [15:0]   result_q, result_d;
  logic          accept;
  logic [15:0]   mul_prod;
  logic          mul_valid;

  // The pipe samples A/B directly on the accepting edge, so its last stage
  // lines up with the DONE cycle without an extra operand register stage.
  tinyalu_mul_pipe #(
    .STAGES (MUL_LATENCY)
  ) u_mul_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .a_i     (A),
    .b_i     (B),
    .valid_i (accept && (op == mul_op)),
    .prod_o  (mul_prod),
    .valid_o (mul_valid)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    done_d   = 1'b0;
    result_d = result_q;
    accept   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          a_d     = A;
          b_d     = B;
          op_d    = op;
          cnt_d   = '0;
          state_d = ((op == mul_op) && (MUL_LATENCY > 1)) ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        if (cnt_q == CW'(CNT_LAST)) state_d = S_DONE;
        else                        cnt_d   = cnt_q + CW'(1);
      end
      S_DONE: begin
        done_d = 1'b1;
        if (op_q == mul_op) result_d = mul_valid ? mul_prod : result_q;
        else                result_d = alu_single(op_q, a_q, b_q, result_q);
        state_d = start ? S_WAIT_REL : S_IDLE;
      end
      S_WAIT_REL: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_tinyalu.sv
// Self-checking bench for tinyalu: vector table plus handshake/reset corner cases,
// with expected results queued at issue and checked when done pulses.
module tb_tinyalu;
  import tinyalu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic [2:0]  op = '0;
  logic        start = 1'b0;
  logic        done;
  logic [15:0] result;

  int checks = 0;
  int failures = 0;
  int done_count = 0;
  bit prev_done = 1'b0;
  logic [15:0] exp_q[$];

  tinyalu #(.MUL_LATENCY(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .A       (A),
    .B       (B),
    .op      (op),
    .start   (start),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [15:0] e;
    if (done) begin
      done_count++;
      checks++;
      if (prev_done) begin
        failures++;
        $display("FAIL done_consecutive got=1 want=0");
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done result=%h want=no_done", result);
      end else begin
        e = exp_q.pop_front();
        if (result !== e) begin
          failures++;
          $display("FAIL result got=%h want=%h", result, e);
        end
      end
    end
    prev_done = done;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Issue one command; operands are scrambled right after acceptance.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                         input logic [15:0] exp_r, input int exp_lat, input int hold,
                         input bit drop_early, input string name);
    int cyc;
    bit seen;
    A = a; B = b; op = o; start = 1'b1;
    exp_q.push_back(exp_r);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        A = ~a;
        B = a ^ 8'h5A;
        op = o ^ 3'b101;
        if (drop_early) start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen || (cyc - 1) != exp_lat) begin
      failures++;
      $display("FAIL latency_%s got=%0d want=%0d seen=%0d", name, cyc - 1, exp_lat, seen);
      if (!seen && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
    end
    repeat (hold) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  o;
    logic [15:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[14];
  int dc0;

  initial begin
    vecs[0]  = '{8'd3,   8'd5,   3'(mul_op), 16'd15,    3};
    vecs[1]  = '{8'd255, 8'd1,   3'(add_op), 16'h0100,  1};
    vecs[2]  = '{8'd255, 8'd255, 3'(mul_op), 16'd65025, 3};
    vecs[3]  = '{8'hF0,  8'h3C,  3'(and_op), 16'h0030,  1};
    vecs[4]  = '{8'hF0,  8'h3C,  3'(xor_op), 16'h00CC,  1};
    vecs[5]  = '{8'd12,  8'd34,  3'(no_op),  16'h00CC,  1};
    vecs[6]  = '{8'h80,  8'h80,  3'(add_op), 16'h0100,  1};
    vecs[7]  = '{8'd0,   8'd77,  3'(mul_op), 16'h0000,  3};
    vecs[8]  = '{8'd7,   8'd9,   3'd5,       16'h0000,  1};
    vecs[9]  = '{8'd200, 8'd100, 3'(mul_op), 16'd20000, 3};
    vecs[10] = '{8'hAA,  8'h55,  3'(xor_op), 16'h00FF,  1};
    vecs[11] = '{8'd1,   8'd2,   3'd6,       16'h00FF,  1};
    vecs[12] = '{8'd9,   8'd9,   3'(rst_op), 16'h0000,  1};
    vecs[13] = '{8'd255, 8'd255, 3'(add_op), 16'h01FE,  1};

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_done", 32'(done_count), 32'd0);

    for (int i = 0; i < 14; i++)
      run_cmd(vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].r, vecs[i].lat, 0, 1'b0, $sformatf("vec%0d", i));

    dc0 = done_count;
    run_cmd(8'd3, 8'd5, 3'(mul_op), 16'd15, 3, 5, 1'b0, "mul_held");
    check("held_single_pulse", 32'(done_count - dc0), 32'd1);
    run_cmd(8'd10, 8'd20, 3'(add_op), 16'd30, 1, 5, 1'b0, "add_held");
    check("held_second_pulse", 32'(done_count - dc0), 32'd2);

    run_cmd(8'd16, 8'd16, 3'(mul_op), 16'd256, 3, 0, 1'b1, "mul_drop_early");
    run_cmd(8'd1, 8'd1, 3'(add_op), 16'd2, 1, 0, 1'b1, "add_drop_early");

    // Abort a multiply with reset while BUSY.
    dc0 = done_count;
    A = 8'd50; B = 8'd50; op = 3'(mul_op); start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0; start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_done", 32'(done_count - dc0), 32'd0);
    check("abort_result", 32'(result), 32'd0);

    run_cmd(8'd100, 8'd3, 3'(mul_op), 16'd300, 3, 0, 1'b0, "mul_after_abort");
    check("result_hold", 32'(result), 32'd300);
    run_cmd(8'd0, 8'd0, 3'(rst_op), 16'h0000, 1, 0, 1'b0, "rst_op");
    check("rst_op_result", 32'(result), 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
